// File: rtl/stage_2_pkg.sv
// Shared definitions for stage_2: FSM encoding, CORDIC gain constant and the
// arctangent table used by the rotation-mode CORDIC lanes.
package stage_2_pkg;

    localparam int ITER_WIDTH = 5;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ROTATE = 2'b01,
        ST_DONE   = 2'b11
    } state_e;

    // 0.607253 * 2^20; pre-scales x so the CORDIC gain cancels out.
    localparam logic [31:0] CORDIC_K = 32'd636751;

    function automatic logic [31:0] atan_q20(input logic [ITER_WIDTH-1:0] idx);
        logic [31:0] val;
        case (idx)
            5'd0:    val = 32'd823550;
            5'd1:    val = 32'd486170;
            5'd2:    val = 32'd256878;
            5'd3:    val = 32'd130395;
            5'd4:    val = 32'd65451;
            5'd5:    val = 32'd32757;
            5'd6:    val = 32'd16383;
            5'd7:    val = 32'd8192;
            5'd8:    val = 32'd4096;
            5'd9:    val = 32'd2048;
            5'd10:   val = 32'd1024;
            5'd11:   val = 32'd512;
            5'd12:   val = 32'd256;
            5'd13:   val = 32'd128;
            5'd14:   val = 32'd64;
            5'd15:   val = 32'd32;
            5'd16:   val = 32'd16;
            5'd17:   val = 32'd8;
            5'd18:   val = 32'd4;
            5'd19:   val = 32'd2;
            default: val = 32'd0;
        endcase
        return val;
    endfunction

    // atan(2^-idx) scaled by 2^(20+guard), matching the widened lane datapath.
    function automatic logic [31:0] atan_scaled(input logic [ITER_WIDTH-1:0] idx,
                                                input int guard);
        return atan_q20(idx) << guard;
    endfunction

endpackage

// File: rtl/stage_2_cordic_lane.sv
// One rotation-mode CORDIC datapath (x/y/z); the shared iteration index and
// arctangent come from the controlling stage.
module cordic_lane #(
    parameter int WIDTH      = 24,
    parameter int ITER_WIDTH = 5
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load,
    input  logic                    en,
    input  logic [ITER_WIDTH-1:0]   i,
    input  logic signed [WIDTH-1:0] atan_i,
    input  logic signed [WIDTH-1:0] x_init,
    input  logic signed [WIDTH-1:0] z_init,
    output logic signed [WIDTH-1:0] x_next
);

    logic signed [WIDTH-1:0] x_r;
    logic signed [WIDTH-1:0] y_r;
    logic signed [WIDTH-1:0] z_r;
    logic signed [WIDTH-1:0] y_next_s;
    logic signed [WIDTH-1:0] z_next_s;

    // One micro-rotation; direction follows the sign of the residual angle.
    always_comb begin
        x_next   = x_r;
        y_next_s = y_r;
        z_next_s = z_r;
        if (z_r[WIDTH-1] == 1'b0) begin
            x_next   = x_r - (y_r >>> i);
            y_next_s = y_r + (x_r >>> i);
            z_next_s = z_r - atan_i;
        end else begin
            x_next   = x_r + (y_r >>> i);
            y_next_s = y_r - (x_r >>> i);
            z_next_s = z_r + atan_i;
        end
    end

    // Lane state: seeded on load, advanced on each enabled rotation cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            x_r <= {WIDTH{1'b0}};
            y_r <= {WIDTH{1'b0}};
            z_r <= {WIDTH{1'b0}};
        end else if (load) begin
            x_r <= x_init;
            y_r <= {WIDTH{1'b0}};
            z_r <= z_init;
        end else if (en) begin
            x_r <= x_next;
            y_r <= y_next_s;
            z_r <= z_next_s;
        end else begin
            x_r <= x_r;
            y_r <= y_r;
            z_r <= z_r;
        end
    end

endmodule

// File: rtl/stage_2.sv
// Second final-adder stage: two parallel iterative CORDIC cosines, with the
// half/square float operands forwarded so all six results leave together.
module stage_2
    import stage_2_pkg::*;
#(
    parameter int FLT_DATA_WIDTH    = 32,
    parameter int CORDIC_DATA_WIDTH = 22,
    parameter int ITERATIONS        = 16,
    parameter int GUARD_BITS        = 2
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                clk_en,
    input  logic                                start,
    input  logic signed [CORDIC_DATA_WIDTH-1:0] x_one,
    input  logic signed [CORDIC_DATA_WIDTH-1:0] x_two,
    input  logic [FLT_DATA_WIDTH-1:0]           half_in_one,
    input  logic [FLT_DATA_WIDTH-1:0]           half_in_two,
    input  logic [FLT_DATA_WIDTH-1:0]           square_in_one,
    input  logic [FLT_DATA_WIDTH-1:0]           square_in_two,
    output logic                                busy,
    output logic                                done,
    output logic signed [CORDIC_DATA_WIDTH-1:0] cos_one,
    output logic signed [CORDIC_DATA_WIDTH-1:0] cos_two,
    output logic [FLT_DATA_WIDTH-1:0]           half_out_one,
    output logic [FLT_DATA_WIDTH-1:0]           half_out_two,
    output logic [FLT_DATA_WIDTH-1:0]           square_out_one,
    output logic [FLT_DATA_WIDTH-1:0]           square_out_two
);

    localparam int LANE_W = CORDIC_DATA_WIDTH + GUARD_BITS;
    localparam logic [ITER_WIDTH-1:0] LAST_ITER = ITER_WIDTH'(ITERATIONS - 1);

    state_e                      state_r;
    logic [ITER_WIDTH-1:0]       iter_r;
    logic [FLT_DATA_WIDTH-1:0]   half_one_r;
    logic [FLT_DATA_WIDTH-1:0]   half_two_r;
    logic [FLT_DATA_WIDTH-1:0]   square_one_r;
    logic [FLT_DATA_WIDTH-1:0]   square_two_r;

    logic                        load_s;
    logic                        en_s;
    logic                        last_s;
    logic signed [LANE_W-1:0]    atan_s;
    logic signed [LANE_W-1:0]    k_s;
    logic signed [LANE_W-1:0]    z_one_init_s;
    logic signed [LANE_W-1:0]    z_two_init_s;
    logic signed [LANE_W-1:0]    x_one_next_s;
    logic signed [LANE_W-1:0]    x_two_next_s;

    // Lane control and operand scaling into the guard-widened datapath.
    always_comb begin
        load_s       = clk_en & start & (state_r == ST_IDLE);
        en_s         = clk_en & (state_r == ST_ROTATE);
        last_s       = (iter_r == LAST_ITER);
        atan_s       = LANE_W'(atan_scaled(iter_r, GUARD_BITS));
        k_s          = LANE_W'(CORDIC_K << GUARD_BITS);
        z_one_init_s = LANE_W'(x_one) <<< GUARD_BITS;
        z_two_init_s = LANE_W'(x_two) <<< GUARD_BITS;
    end

    cordic_lane #(
        .WIDTH      (LANE_W),
        .ITER_WIDTH (ITER_WIDTH)
    ) u_lane_one (
        .clk    (clk),
        .rst    (rst),
        .load   (load_s),
        .en     (en_s),
        .i      (iter_r),
        .atan_i (atan_s),
        .x_init (k_s),
        .z_init (z_one_init_s),
        .x_next (x_one_next_s)
    );

    cordic_lane #(
        .WIDTH      (LANE_W),
        .ITER_WIDTH (ITER_WIDTH)
    ) u_lane_two (
        .clk    (clk),
        .rst    (rst),
        .load   (load_s),
        .en     (en_s),
        .i      (iter_r),
        .atan_i (atan_s),
        .x_init (k_s),
        .z_init (z_two_init_s),
        .x_next (x_two_next_s)
    );

    // Sequencer, operand capture and output registers. The last rotation
    // publishes the post-rotation x so done rises with the DONE state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r        <= ST_IDLE;
            iter_r         <= {ITER_WIDTH{1'b0}};
            busy           <= 1'b0;
            done           <= 1'b0;
            cos_one        <= {CORDIC_DATA_WIDTH{1'b0}};
            cos_two        <= {CORDIC_DATA_WIDTH{1'b0}};
            half_one_r     <= {FLT_DATA_WIDTH{1'b0}};
            half_two_r     <= {FLT_DATA_WIDTH{1'b0}};
            square_one_r   <= {FLT_DATA_WIDTH{1'b0}};
            square_two_r   <= {FLT_DATA_WIDTH{1'b0}};
            half_out_one   <= {FLT_DATA_WIDTH{1'b0}};
            half_out_two   <= {FLT_DATA_WIDTH{1'b0}};
            square_out_one <= {FLT_DATA_WIDTH{1'b0}};
            square_out_two <= {FLT_DATA_WIDTH{1'b0}};
        end else if (clk_en) begin
            done <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        state_r      <= ST_ROTATE;
                        iter_r       <= {ITER_WIDTH{1'b0}};
                        busy         <= 1'b1;
                        half_one_r   <= half_in_one;
                        half_two_r   <= half_in_two;
                        square_one_r <= square_in_one;
                        square_two_r <= square_in_two;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_ROTATE: begin
                    if (last_s) begin
                        state_r        <= ST_DONE;
                        iter_r         <= {ITER_WIDTH{1'b0}};
                        busy           <= 1'b0;
                        done           <= 1'b1;
                        cos_one        <= x_one_next_s[LANE_W-1:GUARD_BITS];
                        cos_two        <= x_two_next_s[LANE_W-1:GUARD_BITS];
                        half_out_one   <= half_one_r;
                        half_out_two   <= half_two_r;
                        square_out_one <= square_one_r;
                        square_out_two <= square_two_r;
                    end else begin
                        iter_r <= iter_r + {{(ITER_WIDTH-1){1'b0}}, 1'b1};
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                    iter_r  <= {ITER_WIDTH{1'b0}};
                    busy    <= 1'b0;
                end
            endcase
        end else begin
            state_r <= state_r;
        end
    end

endmodule
